chess_board_store: RTL and testbench

- Upstream neighbour of the VGA display stage. Owns the 64-square board state plus the turn word, and serves them on the display's chess_address/chess_data read port.
- Applies move, highlight and clear commands arriving over a valid/ready handshake from game logic, one state write per cycle.
- Keeps the display-visible word format stable throughout.

---
 rtl/chess_board_store_pkg.sv | 80 ++++++++
 rtl/chess_board_store_regs.sv | 55 +++++
 rtl/chess_board_store.sv | 191 +++++++++++++++++++
 tb/tb_chess_board_store.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/chess_board_store_pkg.sv
// ---------------------------------------------------------------------------
// chess_board_store_pkg
// Shared definitions for the board store and the display stage: piece and
// colour codes, command op codes, FSM states, read-map constants and the
// initial-position helpers.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package chess_board_store_pkg;

  // Read address that returns the turn word
  localparam logic [11:0] TURN_ADDR   = 12'd66;

  // One-hot square colours for the checker pattern
  localparam logic [3:0]  DARK_COLOR  = 4'h8;   // (row+col) even
  localparam logic [3:0]  LIGHT_COLOR = 4'h4;   // (row+col) odd

  // Piece type codes (square word bits 3:1)
  localparam logic [2:0]  PT_EMPTY  = 3'd0;
  localparam logic [2:0]  PT_KNIGHT = 3'd1;
  localparam logic [2:0]  PT_KING   = 3'd2;
  localparam logic [2:0]  PT_QUEEN  = 3'd3;
  localparam logic [2:0]  PT_BISHOP = 3'd4;
  localparam logic [2:0]  PT_ROOK   = 3'd5;
  localparam logic [2:0]  PT_PAWN   = 3'd6;

  // Piece colour codes (square word bit 0)
  localparam logic        PC_WHITE  = 1'b0;
  localparam logic        PC_BLACK  = 1'b1;

  typedef enum logic [1:0] {
    OP_MOVE      = 2'd0,
    OP_HIGHLIGHT = 2'd1,
    OP_CLEAR_HL  = 2'd2,
    OP_INIT      = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MV_DST  = 3'd1,
    ST_MV_SRC  = 3'd2,
    ST_MV_TURN = 3'd3,
    ST_SWEEP   = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  // Checker-pattern colour of a square {row[2:0], col[2:0]}
  function automatic logic [3:0] checker_color(input logic [5:0] sq);
    return (sq[3] ^ sq[0]) ? LIGHT_COLOR : DARK_COLOR;
  endfunction

  // Full square word of the starting position
  function automatic logic [7:0] init_word(input logic [5:0] sq);
    logic [2:0] row;
    logic [2:0] col;
    logic [2:0] ptype;
    logic       pcol;
    row   = sq[5:3];
    col   = sq[2:0];
    ptype = PT_EMPTY;
    pcol  = PC_WHITE;
    if (row == 3'd0 || row == 3'd7) begin
      case (col)
        3'd0, 3'd7: ptype = PT_ROOK;
        3'd1, 3'd6: ptype = PT_KNIGHT;
        3'd2, 3'd5: ptype = PT_BISHOP;
        3'd3:       ptype = PT_QUEEN;
        default:    ptype = PT_KING;
      endcase
    end else if (row == 3'd1 || row == 3'd6) begin
      ptype = PT_PAWN;
    end
    if (row >= 3'd6) pcol = PC_BLACK;
    return {checker_color(sq), ptype, pcol};
  endfunction

endpackage

`default_nettype wire

// File: rtl/chess_board_store_regs.sv
// ---------------------------------------------------------------------------
// chess_board_store_regs
// 64 x 8 board register array. One write port, two combinational peek ports
// for the command FSM, and one registered 32-bit display read port that also
// maps the turn word.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module chess_board_store_regs
  import chess_board_store_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_we,
  input  logic [5:0]  i_waddr,
  input  logic [7:0]  i_wdata,
  input  logic [5:0]  i_pa_addr,
  output logic [7:0]  o_pa_data,
  input  logic [5:0]  i_pb_addr,
  output logic [7:0]  o_pb_data,
  input  logic [11:0] i_rd_addr,
  input  logic        i_turn,
  output logic [31:0] o_rd_data
);

  logic [63:0][7:0] w_sq;
  logic [31:0]      r_rd_data;

  for (genvar i = 0; i < 64; i++) begin : g_sq
    logic [7:0] r_sq;
    // Square register: starting position on reset, written by the single port
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)                              r_sq <= init_word(6'(i));
      else if (i_we && (i_waddr == 6'(i)))       r_sq <= i_wdata;
    end
    assign w_sq[i] = r_sq;
  end

  assign o_pa_data = w_sq[i_pa_addr];
  assign o_pb_data = w_sq[i_pb_addr];

  // Display read: samples pre-write contents, so same-cycle writes read old
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                      r_rd_data <= '0;
    else if (i_rd_addr < 12'd64)       r_rd_data <= {24'b0, w_sq[i_rd_addr[5:0]]};
    else if (i_rd_addr == TURN_ADDR)   r_rd_data <= {31'b0, i_turn};
    else                               r_rd_data <= '0;
  end

  assign o_rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/chess_board_store.sv
// ---------------------------------------------------------------------------
// chess_board_store
// Owns the chess board and turn word, serves them on the display read port
// and applies MOVE / HIGHLIGHT / CLEAR_HL / INIT commands one write per cycle.
// Optional macro PROMOTION_EN: pawns reaching the last rank become queens.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module chess_board_store
  import chess_board_store_pkg::*;
(
  input  logic        iVGA_CLK,
  input  logic        iRST_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [5:0]  cmd_from,
  input  logic [5:0]  cmd_to,
  input  logic [3:0]  cmd_color,
  input  logic [11:0] chess_address,
  output logic [31:0] chess_data,
  output logic        move_done,
  output logic        move_err
);

  state_e     r_state;
  cmd_op_e    r_op;
  logic [5:0] r_from;
  logic [5:0] r_to;
  logic [3:0] r_piece;
  logic [5:0] r_cnt;
  logic       r_turn;
  logic       r_cmd_ready;
  logic       r_move_done;
  logic       r_move_err;

  logic       w_accept;
  logic       w_we;
  logic [5:0] w_waddr;
  logic [7:0] w_wdata;
  logic [5:0] w_pa_addr;
  logic [5:0] w_pb_addr;
  logic [7:0] w_pa_data;
  logic [7:0] w_pb_data;
  logic [3:0] w_new_piece;
  logic [3:0] w_hl_color;

  assign w_accept = cmd_valid && r_cmd_ready;

  chess_board_store_regs u_regs (
    .i_clk     (iVGA_CLK),
    .i_rst_n   (iRST_n),
    .i_we      (w_we),
    .i_waddr   (w_waddr),
    .i_wdata   (w_wdata),
    .i_pa_addr (w_pa_addr),
    .o_pa_data (w_pa_data),
    .i_pb_addr (w_pb_addr),
    .o_pb_data (w_pb_data),
    .i_rd_addr (chess_address),
    .i_turn    (r_turn),
    .o_rd_data (chess_data)
  );

  // Piece written to the destination, optionally promoting a pawn
  always_comb begin
    w_new_piece = r_piece;
`ifdef PROMOTION_EN
    if (r_piece[3:1] == PT_PAWN &&
        ((r_piece[0] == PC_WHITE && r_to[5:3] == 3'd7) ||
         (r_piece[0] == PC_BLACK && r_to[5:3] == 3'd0)))
      w_new_piece = {PT_QUEEN, r_piece[0]};
`endif
  end

  // Peek addresses and the single board write port, driven from FSM state
  always_comb begin
    w_pa_addr  = (r_state == ST_IDLE) ? cmd_from : r_from;
    w_pb_addr  = (r_state == ST_IDLE)  ? cmd_to :
                 (r_state == ST_SWEEP) ? r_cnt  : r_to;
    w_hl_color = (cmd_color == 4'd0) ? checker_color(cmd_to) : cmd_color;
    w_we       = 1'b0;
    w_waddr    = 6'd0;
    w_wdata    = 8'd0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && cmd_op == OP_HIGHLIGHT) begin
          w_we    = 1'b1;
          w_waddr = cmd_to;
          w_wdata = {w_hl_color, w_pb_data[3:0]};
        end
      end
      ST_MV_DST: begin
        w_we    = 1'b1;
        w_waddr = r_to;
        w_wdata = {w_pb_data[7:4], w_new_piece};
      end
      ST_MV_SRC: begin
        w_we    = 1'b1;
        w_waddr = r_from;
        w_wdata = {w_pa_data[7:4], 4'd0};
      end
      ST_SWEEP: begin
        w_we    = 1'b1;
        w_waddr = r_cnt;
        w_wdata = (r_op == OP_INIT) ? init_word(r_cnt)
                                    : {checker_color(r_cnt), w_pb_data[3:0]};
      end
      default: ;
    endcase
  end

  // Command FSM with registered handshake and completion outputs
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_state     <= ST_IDLE;
      r_op        <= OP_MOVE;
      r_from      <= 6'd0;
      r_to        <= 6'd0;
      r_piece     <= 4'd0;
      r_cnt       <= 6'd0;
      r_turn      <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_move_done <= 1'b0;
      r_move_err  <= 1'b0;
    end else begin
      r_move_done <= 1'b0;
      r_move_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op        <= cmd_op_e'(cmd_op);
            r_from      <= cmd_from;
            r_to        <= cmd_to;
            r_piece     <= w_pa_data[3:0];
            r_cnt       <= 6'd0;
            r_cmd_ready <= 1'b0;
            case (cmd_op_e'(cmd_op))
              OP_MOVE: begin
                if (cmd_from == cmd_to || w_pa_data[3:1] == PT_EMPTY) begin
                  r_state     <= ST_DONE;
                  r_move_done <= 1'b1;
                  r_move_err  <= 1'b1;
                end else begin
                  r_state <= ST_MV_DST;
                end
              end
              OP_HIGHLIGHT: begin
                r_state     <= ST_DONE;
                r_move_done <= 1'b1;
              end
              default: r_state <= ST_SWEEP;
            endcase
          end
        end
        ST_MV_DST:  r_state <= ST_MV_SRC;
        ST_MV_SRC:  r_state <= ST_MV_TURN;
        ST_MV_TURN: begin
          r_turn      <= ~r_turn;
          r_state     <= ST_DONE;
          r_move_done <= 1'b1;
        end
        ST_SWEEP: begin
          if (r_cnt == 6'd63) begin
            if (r_op == OP_INIT) r_turn <= 1'b0;
            r_state     <= ST_DONE;
            r_move_done <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end
        ST_DONE: begin
          r_state     <= ST_IDLE;
          r_cmd_ready <= 1'b1;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_cmd_ready <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign move_done = r_move_done;
  assign move_err  = r_move_err;

endmodule

`default_nettype wire

// File: tb/tb_chess_board_store.sv
// ---------------------------------------------------------------------------
// tb_chess_board_store
// Randomized self-checking bench for chess_board_store against a square-array
// reference model of the board and turn.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_chess_board_store;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [5:0]  cmd_from = 6'd0;
  logic [5:0]  cmd_to = 6'd0;
  logic [3:0]  cmd_color = 4'd0;
  logic [11:0] chess_address = 12'd0;
  logic [31:0] chess_data;
  logic        move_done;
  logic        move_err;

  int n_cmp = 0;
  int n_bad = 0;
  int board [64];
  int turn;

  always #5 clk = ~clk;

  chess_board_store dut (
    .iVGA_CLK      (clk),
    .iRST_n        (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_from      (cmd_from),
    .cmd_to        (cmd_to),
    .cmd_color     (cmd_color),
    .chess_address (chess_address),
    .chess_data    (chess_data),
    .move_done     (move_done),
    .move_err      (move_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int sq_color(int sq);
    return ((((sq / 8) + (sq % 8)) % 2) == 0) ? 8 : 4;
  endfunction

  function automatic int start_word(int sq);
    int back [8] = '{5, 1, 4, 3, 2, 4, 1, 5};
    int r = sq / 8;
    int c = sq % 8;
    int t = 0;
    int b = 0;
    if (r == 0 || r == 7) t = back[c];
    else if (r == 1 || r == 6) t = 6;
    if (r >= 6) b = 1;
    return sq_color(sq) * 16 + t * 2 + b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) board[i] = start_word(i);
    turn = 0;
  endtask

  function automatic int model_read(int a);
    if (a < 64) return board[a];
    if (a == 66) return turn;
    return 0;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_chk(input int a, input string tag);
    chess_address = a[11:0];
    tick();
    chk(tag, chess_data, model_read(a));
  endtask

  task automatic do_cmd(input int op, input int from, input int to, input int color);
    int cyc;
    int exp_cyc;
    int exp_err;
    int old_to;
    int piece;
    int waits;
    waits = 0;
    while (cmd_ready !== 1'b1 && waits < 200) begin
      tick();
      waits++;
    end
    chk("ready_before_cmd", cmd_ready, 1);
    old_to    = board[to];
    cmd_valid = 1'b1;
    cmd_op    = op[1:0];
    cmd_from  = from[5:0];
    cmd_to    = to[5:0];
    cmd_color = color[3:0];
    if (op == 1) chess_address = to[11:0];
    // model update
    exp_err = 0;
    case (op)
      0: begin
        if (from == to || ((board[from] / 2) % 8) == 0) begin
          exp_err = 1;
          exp_cyc = 1;
        end else begin
          piece = board[from] % 16;
`ifdef PROMOTION_EN
          if (piece / 2 == 6 && ((piece % 2 == 0 && to / 8 == 7) ||
                                 (piece % 2 == 1 && to / 8 == 0)))
            piece = 6 + (piece % 2);
`endif
          board[to]   = (board[to] / 16) * 16 + piece;
          board[from] = (board[from] / 16) * 16;
          turn        = 1 - turn;
          exp_cyc     = 4;
        end
      end
      1: begin
        board[to] = ((color == 0) ? sq_color(to) : color) * 16 + board[to] % 16;
        exp_cyc   = 1;
      end
      2: begin
        for (int i = 0; i < 64; i++) board[i] = sq_color(i) * 16 + board[i] % 16;
        exp_cyc = 65;
      end
      default: begin
        model_reset();
        exp_cyc = 65;
      end
    endcase
    tick();
    if (op == 1) chk("read_old_on_write", chess_data, old_to);
    chk("ready_low_busy", cmd_ready, 0);
    // junk commands while busy must be ignored
    cmd_op   = 2'($urandom_range(0, 3));
    cmd_from = 6'($urandom_range(0, 63));
    cmd_to   = 6'($urandom_range(0, 63));
    cyc = 1;
    while (move_done !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
    cmd_valid = 1'b0;
    chk("done_latency", cyc, exp_cyc);
    chk("move_err", move_err, exp_err);
    tick();
    chk("done_one_cycle", move_done, 0);
    chk("ready_after_done", cmd_ready, 1);
  endtask

  task automatic read_some(input int n);
    for (int k = 0; k < n; k++) read_chk($urandom_range(0, 63), "rand_square");
    read_chk(66, "turn_word");
  endtask

  task automatic read_all(input string tag);
    for (int a = 0; a < 64; a++) read_chk(a, tag);
    read_chk(66, "turn_word");
  endtask

  int colors [5] = '{0, 1, 2, 4, 8};

  initial begin
    int op;
    int from;
    int to;
    int sel;
    model_reset();
    repeat (3) tick();
    // reset state
    chk("rst_chess_data", chess_data, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_move_done", move_done, 0);
    chk("rst_move_err", move_err, 0);
    rst_n = 1'b1;
    tick();
    read_chk(0, "init_a0");
    read_chk(4, "init_a4");
    read_chk(12, "init_a12");
    read_chk(60, "init_a60");
    read_chk(66, "init_turn");
    read_chk(64, "unmapped_64");
    read_chk(65, "unmapped_65");
    read_chk(4095, "unmapped_top");
    // directed commands
    do_cmd(0, 12, 28, 0);
    read_chk(28, "mv_dst");
    read_chk(12, "mv_src");
    read_chk(66, "mv_turn");
    do_cmd(0, 20, 28, 0);   // empty source
    read_chk(28, "rej_dst");
    read_chk(66, "rej_turn");
    do_cmd(0, 5, 5, 0);     // from == to
    read_chk(5, "rej_same");
    do_cmd(1, 27, 0, 2);
    read_chk(27, "hl_color");
    do_cmd(1, 27, 35, 0);   // colour 0 -> checker default
    read_chk(35, "hl_default");
    do_cmd(2, 0, 0, 0);
    read_chk(27, "clear_hl");
    // randomized commands
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 19);
      from = $urandom_range(0, 63);
      for (int t = 0; t < 8 && board[from] % 16 == 0; t++) from = $urandom_range(0, 63);
      to = $urandom_range(0, 63);
      if (sel < 13) op = 0;
      else if (sel < 18) op = 1;
      else if (sel == 18) op = 2;
      else op = 3;
      do_cmd(op, from, to, colors[$urandom_range(0, 4)]);
      read_some(3);
    end
    // pawn to last rank
    do_cmd(3, 0, 0, 0);
    do_cmd(0, 12, 52, 0);
    do_cmd(0, 52, 60, 0);
    read_chk(60, "promo_white");
    do_cmd(0, 51, 3, 0);
    read_chk(3, "promo_black");
    // reset in the middle of INIT
    do_cmd(0, 11, 27, 0);
    cmd_valid = 1'b1;
    cmd_op    = 2'd3;
    tick();
    cmd_valid = 1'b0;
    repeat (30) tick();
    rst_n = 1'b0;
    #2;
    model_reset();
    chk("midrst_ready", cmd_ready, 1);
    chk("midrst_done", move_done, 0);
    chk("midrst_data", chess_data, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    read_all("post_reset_board");
    do_cmd(0, 1, 18, 0);
    read_chk(18, "post_reset_move");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
